// File: rtl/des_round_ctrl.sv
// Round sequencer for an iterative 16-round DES datapath: start/result handshakes,
// round counter, key-schedule rotate control and datapath strobes.
module des_round_ctrl #(
    parameter int ACK_TIMEOUT = 0,
    parameter int TO_W        = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic            decrypt,
    input  logic            abort,
    output logic            key_load,
    output logic            data_load,
    output logic            round_en,
    output logic [3:0]      round_idx,
    output logic [1:0]      shift_amt,
    output logic            shift_dir,
    output logic            out_latch,
    output logic            out_valid,
    input  logic            out_ack,
    output logic            busy,
    output logic            timeout,
    output logic [2:0]      dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ROUND = 3'd2;
    localparam logic [2:0] S_FINAL = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    logic [2:0]      state_q, state_d;
    logic [3:0]      round_q, round_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            mode_q, mode_d;
    logic            timeout_q, timeout_d;

    // Handshakes: a start transfers on a cycle where start_valid and start_ready
    // are both high; out_valid is held in DONE until out_ack or the ack timeout.
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        to_cnt_d  = to_cnt_q;
        mode_d    = mode_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    mode_d    = decrypt;
                    timeout_d = 1'b0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                round_d = 4'd0;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (round_q == 4'd15) begin
                    round_d = 4'd0;
                    state_d = S_FINAL;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_FINAL: begin
                to_cnt_d = '0;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ack) begin
                    to_cnt_d = '0;
                    state_d  = S_IDLE;
                end else if (ACK_TIMEOUT > 0) begin
                    if (to_cnt_q == TO_LAST) begin
                        to_cnt_d  = '0;
                        timeout_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything, including a start in IDLE; the sticky flag survives.
        if (abort) begin
            state_d   = S_IDLE;
            round_d   = 4'd0;
            to_cnt_d  = '0;
            mode_d    = mode_q;
            timeout_d = timeout_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            round_q   <= 4'd0;
            to_cnt_q  <= '0;
            mode_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            to_cnt_q  <= to_cnt_d;
            mode_q    <= mode_d;
            timeout_q <= timeout_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign key_load    = (state_q == S_LOAD);
    assign data_load   = (state_q == S_LOAD);
    assign round_en    = (state_q == S_ROUND);
    assign out_latch   = (state_q == S_FINAL);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign timeout     = timeout_q;
    assign dbg_state   = state_q;
    assign round_idx   = round_en ? round_q : 4'd0;
    assign shift_dir   = round_en & mode_q;

    // Decrypt skips the first rotate so its 27 right shifts undo encrypt's 28 left.
    always_comb begin
        shift_amt = 2'd0;
        if (round_en) begin
            if (round_q == 4'd0)
                shift_amt = mode_q ? 2'd0 : 2'd1;
            else if (round_q == 4'd1 || round_q == 4'd8 || round_q == 4'd15)
                shift_amt = 2'd1;
            else
                shift_amt = 2'd2;
        end
    end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Self-checking bench for des_round_ctrl: one instance waits forever for ack,
// a second (ACK_TIMEOUT=4) shares the inputs and covers the timeout path.
module tb_des_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start_valid, decrypt, abort, out_ack;

    logic       a_start_ready, a_key_load, a_data_load, a_round_en, a_shift_dir;
    logic       a_out_latch, a_out_valid, a_busy, a_timeout;
    logic [3:0] a_round_idx;
    logic [1:0] a_shift_amt;
    logic [2:0] a_state;

    logic       b_start_ready, b_key_load, b_data_load, b_round_en, b_shift_dir;
    logic       b_out_latch, b_out_valid, b_busy, b_timeout;
    logic [3:0] b_round_idx;
    logic [1:0] b_shift_amt;
    logic [2:0] b_state;

    des_round_ctrl #(.ACK_TIMEOUT(0), .TO_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(a_start_ready),
        .decrypt(decrypt), .abort(abort), .key_load(a_key_load), .data_load(a_data_load),
        .round_en(a_round_en), .round_idx(a_round_idx), .shift_amt(a_shift_amt),
        .shift_dir(a_shift_dir), .out_latch(a_out_latch), .out_valid(a_out_valid),
        .out_ack(out_ack), .busy(a_busy), .timeout(a_timeout), .dbg_state(a_state)
    );

    des_round_ctrl #(.ACK_TIMEOUT(4), .TO_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(b_start_ready),
        .decrypt(decrypt), .abort(abort), .key_load(b_key_load), .data_load(b_data_load),
        .round_en(b_round_en), .round_idx(b_round_idx), .shift_amt(b_shift_amt),
        .shift_dir(b_shift_dir), .out_latch(b_out_latch), .out_valid(b_out_valid),
        .out_ack(out_ack), .busy(b_busy), .timeout(b_timeout), .dbg_state(b_state)
    );

    localparam int W = 15;
    logic [W-1:0] a_vec, b_vec;
    assign a_vec = {a_start_ready, a_key_load, a_data_load, a_round_en, a_round_idx,
                    a_shift_amt, a_shift_dir, a_out_latch, a_out_valid, a_busy, a_timeout};
    assign b_vec = {b_start_ready, b_key_load, b_data_load, b_round_en, b_round_idx,
                    b_shift_amt, b_shift_dir, b_out_latch, b_out_valid, b_busy, b_timeout};

    int enc_amt[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int dec_amt[16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic [W-1:0] exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    bit  sel_b    = 1'b0;
    bit  exp_to   = 1'b0;

    function automatic logic [W-1:0] mk(bit sr, bit kl, bit dl, bit re, logic [3:0] idx,
                                        logic [1:0] sa, bit sd, bit ol, bit ov, bit bz, bit to);
        return {sr, kl, dl, re, idx, sa, sd, ol, ov, bz, to};
    endfunction

    function automatic logic [W-1:0] st_idle(bit to);
        return mk(1, 0, 0, 0, 4'd0, 2'd0, 0, 0, 0, 0, to);
    endfunction
    function automatic logic [W-1:0] st_load(bit to);
        return mk(0, 1, 1, 0, 4'd0, 2'd0, 0, 0, 0, 1, to);
    endfunction
    function automatic logic [W-1:0] st_round(int i, bit mode, bit to);
        int amt;
        amt = mode ? dec_amt[i] : enc_amt[i];
        return mk(0, 0, 0, 1, 4'(i), 2'(amt), mode, 0, 0, 1, to);
    endfunction
    function automatic logic [W-1:0] st_final(bit to);
        return mk(0, 0, 0, 0, 4'd0, 2'd0, 0, 1, 0, 1, to);
    endfunction
    function automatic logic [W-1:0] st_done(bit to);
        return mk(0, 0, 0, 0, 4'd0, 2'd0, 0, 0, 1, 1, to);
    endfunction

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Push the expected outputs for the next edge, then pop and compare after it.
    task automatic expect_step(input string tag, input logic [W-1:0] e);
        logic [W-1:0] want;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check_eq(tag, sel_b ? b_vec : a_vec, want);
    endtask

    task automatic run_block(input bit mode, input bit hold_sv, input int ack_round,
                             input int abort_idx, input int rst_idx,
                             input int done_cycles, input bit do_ack);
        logic [W-1:0] sum;
        sum         = '0;
        start_valid = 1'b1;
        decrypt     = mode;
        exp_to      = 1'b0;
        expect_step("load", st_load(exp_to));
        if (!hold_sv) start_valid = 1'b0;
        decrypt = 1'($urandom_range(0, 1));
        for (int i = 0; i < 16; i++) begin
            expect_step($sformatf("round%0d_m%0d", i, mode), st_round(i, mode, exp_to));
            sum = sum + W'(sel_b ? b_shift_amt : a_shift_amt);
            if (i == abort_idx) begin
                abort = 1'b1;
                expect_step("abort_idle", st_idle(exp_to));
                abort = 1'b0;
                return;
            end
            if (i == rst_idx) begin
                rst_n       = 1'b0;
                abort       = 1'b1;
                start_valid = 1'b1;
                exp_to      = 1'b0;
                expect_step("reset_mid_round", st_idle(1'b0));
                rst_n       = 1'b1;
                abort       = 1'b0;
                start_valid = 1'b0;
                return;
            end
            out_ack = (i == ack_round);
        end
        out_ack = 1'b0;
        check_eq($sformatf("shift_sum_m%0d", mode), sum, mode ? W'(27) : W'(28));
        expect_step("final", st_final(exp_to));
        for (int d = 0; d < done_cycles; d++)
            expect_step($sformatf("done%0d", d), st_done(exp_to));
        if (do_ack) begin
            out_ack = 1'b1;
            expect_step("ack_idle", st_idle(exp_to));
            out_ack = 1'b0;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start_valid = 1'b0;
        decrypt     = 1'b0;
        abort       = 1'b0;
        out_ack     = 1'b0;

        for (int i = 0; i < 3; i++) expect_step("reset", st_idle(1'b0));
        rst_n = 1'b1;
        expect_step("idle_after_reset", st_idle(1'b0));

        // Encrypt with ack on the 4th DONE cycle, then decrypt with an early ack.
        run_block(1'b0, 1'b0, -1, -1, -1, 4, 1'b1);
        run_block(1'b1, 1'b0, -1, -1, -1, 2, 1'b1);

        start_valid = 1'b1;
        abort       = 1'b1;
        expect_step("abort_beats_start", st_idle(1'b0));
        start_valid = 1'b0;
        abort       = 1'b0;
        expect_step("idle_after_abort", st_idle(1'b0));

        run_block(1'b0, 1'b0, -1, 7, -1, 0, 1'b0);
        run_block(1'b0, 1'b0, -1, -1, -1, 1, 1'b1);

        // start_valid held high and a stray ack mid-round; the next transfer happens only from IDLE.
        run_block(1'b1, 1'b1, 5, -1, -1, 3, 1'b1);
        expect_step("restart_from_idle", st_load(1'b0));
        start_valid = 1'b0;
        abort       = 1'b1;
        expect_step("abort_after_restart", st_idle(1'b0));
        abort = 1'b0;

        run_block(1'b1, 1'b0, -1, -1, 10, 0, 1'b0);
        expect_step("idle_after_reset_mid", st_idle(1'b0));

        // Timeout path observed on the ACK_TIMEOUT=4 instance.
        sel_b = 1'b1;
        run_block(1'b0, 1'b0, -1, -1, -1, 4, 1'b0);
        exp_to = 1'b1;
        expect_step("timeout_idle", st_idle(1'b1));
        check_eq("wait_forever_done", a_vec, st_done(1'b0));
        abort = 1'b1;
        expect_step("abort_keeps_timeout", st_idle(1'b1));
        abort = 1'b0;
        check_eq("wait_forever_aborted", a_vec, st_idle(1'b0));

        run_block(1'b1, 1'b0, -1, -1, -1, 4, 1'b1);
        run_block(1'b0, 1'b0, -1, -1, -1, 4, 1'b0);
        exp_to = 1'b1;
        expect_step("timeout_again", st_idle(1'b1));
        rst_n = 1'b0;
        expect_step("reset_clears_timeout", st_idle(1'b0));
        rst_n = 1'b1;
        check_eq("reset_a_idle", a_vec, st_idle(1'b0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
